// File: rtl/pll_reset_sequencer.sv
// PLL start-up and supervision sequencer: holds the PLL in reset, qualifies lock,
// holds downstream logic in reset while the clock settles, and restarts on any lock loss.
module pll_reset_sequencer #(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_FILTER   = 64,
  parameter int LOCK_TIMEOUT  = 65536,
  parameter int SETTLE_CYCLES = 256,
  parameter int CNT_W         = 8
) (
  input  logic             clkin,
  input  logic             reset,
  input  logic             pll_lock,
  output logic             pll_reset,
  output logic             sys_rst,
  output logic             ready,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] relock_cnt,
  output logic             timeout_err
);

  // One shared cycle counter serves PLL_RST length, lock timeout and settle time.
  localparam int MAX_A   = (RST_CYCLES > SETTLE_CYCLES) ? RST_CYCLES : SETTLE_CYCLES;
  localparam int MAX_CYC = (MAX_A > LOCK_TIMEOUT) ? MAX_A : LOCK_TIMEOUT;
  localparam int CYC_W   = $clog2(MAX_CYC + 1);
  localparam int FLT_W   = $clog2(LOCK_FILTER + 1);

  localparam logic [CYC_W-1:0] RST_LAST = CYC_W'(RST_CYCLES - 1);
  localparam logic [CYC_W-1:0] TMO_LAST = CYC_W'(LOCK_TIMEOUT - 1);
  localparam logic [CYC_W-1:0] SET_LAST = CYC_W'(SETTLE_CYCLES - 1);
  localparam logic [FLT_W-1:0] FLT_LAST = FLT_W'(LOCK_FILTER - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    ST_PLL_RST   = 2'd0,
    ST_WAIT_LOCK = 2'd1,
    ST_SETTLE    = 2'd2,
    ST_RUN       = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [CYC_W-1:0] cyc_q, cyc_d;
  logic [FLT_W-1:0] flt_q, flt_d;
  logic [CNT_W-1:0] relock_q, relock_d;
  logic             tmo_err_q, tmo_err_d;
  logic             sync1_q, lock_s_q;
  logic             pll_reset_q, sys_rst_q, ready_q;
  logic             relock_inc;

  // Next-state, counter and sticky-flag logic.
  always_comb begin
    state_d    = state_q;
    cyc_d      = cyc_q + CYC_W'(1);
    flt_d      = flt_q;
    relock_inc = 1'b0;
    tmo_err_d  = tmo_err_q;
    case (state_q)
      ST_PLL_RST: begin
        if (cyc_q == RST_LAST) begin
          state_d = ST_WAIT_LOCK;
          cyc_d   = '0;
          flt_d   = '0;
        end else begin
          state_d = ST_PLL_RST;
        end
      end
      ST_WAIT_LOCK: begin
        flt_d = lock_s_q ? (flt_q + FLT_W'(1)) : '0;
        // Lock completion beats a simultaneous timeout.
        if (lock_s_q && (flt_q == FLT_LAST)) begin
          state_d = ST_SETTLE;
          cyc_d   = '0;
          flt_d   = '0;
        end else if (cyc_q == TMO_LAST) begin
          state_d    = ST_PLL_RST;
          cyc_d      = '0;
          flt_d      = '0;
          relock_inc = 1'b1;
          tmo_err_d  = 1'b1;
        end else begin
          state_d = ST_WAIT_LOCK;
        end
      end
      ST_SETTLE: begin
        if (!lock_s_q) begin
          state_d    = ST_PLL_RST;
          cyc_d      = '0;
          relock_inc = 1'b1;
        end else if (cyc_q == SET_LAST) begin
          state_d = ST_RUN;
          cyc_d   = '0;
        end else begin
          state_d = ST_SETTLE;
        end
      end
      ST_RUN: begin
        cyc_d = cyc_q;
        if (!lock_s_q) begin
          state_d    = ST_PLL_RST;
          cyc_d      = '0;
          relock_inc = 1'b1;
        end else begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_PLL_RST;
        cyc_d   = '0;
        flt_d   = '0;
      end
    endcase

    if (relock_inc && (relock_q != CNT_MAX)) begin
      relock_d = relock_q + CNT_W'(1);
    end else begin
      relock_d = relock_q;
    end
  end

  // State, counters, lock synchronizer and registered outputs.
  always_ff @(posedge clkin) begin
    if (reset) begin
      state_q     <= ST_PLL_RST;
      cyc_q       <= '0;
      flt_q       <= '0;
      relock_q    <= '0;
      tmo_err_q   <= 1'b0;
      sync1_q     <= 1'b0;
      lock_s_q    <= 1'b0;
      pll_reset_q <= 1'b1;
      sys_rst_q   <= 1'b1;
      ready_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cyc_q       <= cyc_d;
      flt_q       <= flt_d;
      relock_q    <= relock_d;
      tmo_err_q   <= tmo_err_d;
      sync1_q     <= pll_lock;
      lock_s_q    <= sync1_q;
      pll_reset_q <= (state_d == ST_PLL_RST);
      sys_rst_q   <= (state_d != ST_RUN);
      ready_q     <= (state_d == ST_RUN);
    end
  end

  assign pll_reset   = pll_reset_q;
  assign sys_rst     = sys_rst_q;
  assign ready       = ready_q;
  assign state       = state_q;
  assign relock_cnt  = relock_q;
  assign timeout_err = tmo_err_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed and randomized bench for pll_reset_sequencer against a timestamp-based
// reference model of the sequencing rules.
module tb_pll_reset_sequencer;

  localparam int P_RST = 4;
  localparam int P_FLT = 8;
  localparam int P_TMO = 32;
  localparam int P_SET = 16;
  localparam int P_CW  = 8;

  logic            clkin = 1'b0;
  logic            reset = 1'b1;
  logic            pll_lock = 1'b0;
  logic            pll_reset, sys_rst, ready, timeout_err;
  logic [1:0]      state;
  logic [P_CW-1:0] relock_cnt;

  int n_checks = 0;
  int n_err    = 0;

  pll_reset_sequencer #(
    .RST_CYCLES(P_RST), .LOCK_FILTER(P_FLT), .LOCK_TIMEOUT(P_TMO),
    .SETTLE_CYCLES(P_SET), .CNT_W(P_CW)
  ) dut (
    .clkin(clkin), .reset(reset), .pll_lock(pll_lock),
    .pll_reset(pll_reset), .sys_rst(sys_rst), .ready(ready), .state(state),
    .relock_cnt(relock_cnt), .timeout_err(timeout_err)
  );

  always #5 clkin = ~clkin;

  // Reference model: phase plus the edge number at which it was entered.
  int m_phase = 0;
  int m_t0    = 0;
  int m_n     = 0;
  int m_run   = 0;
  int m_relock = 0;
  bit m_tmo   = 1'b0;
  bit lq[$]   = '{1'b0, 1'b0};

  task automatic m_enter(input int p);
    m_phase = p;
    m_t0    = m_n;
    m_run   = 0;
  endtask

  task automatic m_lose();
    m_enter(0);
    if (m_relock < (1 << P_CW) - 1) m_relock++;
  endtask

  task automatic model_edge(input bit lk, input bit rs);
    bit ls;
    int e;
    m_n++;
    if (rs) begin
      m_enter(0);
      m_relock = 0;
      m_tmo    = 1'b0;
      lq       = '{1'b0, 1'b0};
    end else begin
      ls = lq.pop_front();
      lq.push_back(lk);
      e = m_n - m_t0;
      case (m_phase)
        0: if (e == P_RST) m_enter(1);
        1: begin
          m_run = ls ? m_run + 1 : 0;
          if (m_run == P_FLT) m_enter(2);
          else if (e == P_TMO) begin m_tmo = 1'b1; m_lose(); end
        end
        2: if (!ls) m_lose(); else if (e == P_SET) m_enter(3);
        3: if (!ls) m_lose();
        default: m_enter(0);
      endcase
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input bit lk, input bit rs);
    logic [31:0] exp_v, obs_v;
    pll_lock = lk;
    reset    = rs;
    @(posedge clkin);
    model_edge(lk, rs);
    #1;
    exp_v = {18'd0, 2'(m_phase), (m_phase == 0), (m_phase != 3), (m_phase == 3),
             8'(m_relock), m_tmo};
    obs_v = {18'd0, state, pll_reset, sys_rst, ready, relock_cnt, timeout_err};
    chk("step", obs_v, exp_v);
  endtask

  // Lock held high; first edge of pll_reset low, SETTLE and ready.
  task automatic seq_times(output int f_pr, output int f_st, output int f_rd);
    f_pr = -1; f_st = -1; f_rd = -1;
    for (int i = 1; i <= 80 && f_rd < 0; i++) begin
      step(1'b1, 1'b0);
      if (f_pr < 0 && pll_reset === 1'b0) f_pr = i;
      if (f_st < 0 && state === 2'd2) f_st = i;
      if (f_rd < 0 && ready === 1'b1) f_rd = i;
    end
  endtask

  initial begin
    int f_pr, f_st, f_rd, k, r1, r2;
    bit seen_low, wrapped, lk;
    logic prev_pr;

    // Lock high from reset release.
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    chk("reset_pll_reset", 32'(pll_reset), 32'd1);
    chk("reset_ready", 32'(ready), 32'd0);
    seq_times(f_pr, f_st, f_rd);
    chk("boot_pll_reset_fall", f_pr, 32'd4);
    chk("boot_settle", f_st, 32'd12);
    chk("boot_ready", f_rd, 32'd28);
    chk("boot_relock", 32'(relock_cnt), 32'd0);

    // One-cycle lock drop in RUN.
    step(1'b0, 1'b0);
    k = 1;
    while (sys_rst !== 1'b1 && k < 10) begin step(1'b1, 1'b0); k++; end
    chk("run_drop_edge", k, 32'd3);
    chk("run_drop_pll_reset", 32'(pll_reset), 32'd1);
    chk("run_drop_relock", 32'(relock_cnt), 32'd1);
    seq_times(f_pr, f_st, f_rd);
    chk("relock_ready", f_rd, 32'd28);

    // Filter restart in WAIT_LOCK.
    step(1'b1, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    k = 10;
    while (state !== 2'd2 && k < 50) begin step(1'b1, 1'b0); k++; end
    chk("filter_settle_edge", k, 32'd20);
    chk("filter_relock", 32'(relock_cnt), 32'd0);

    // Lock drop during SETTLE.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    seen_low = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b0);
      if (sys_rst !== 1'b1) seen_low = 1'b1;
    end
    chk("settle_drop_sys_rst_low", 32'(seen_low), 32'd0);
    chk("settle_drop_relock", 32'(relock_cnt), 32'd1);

    // Lock tied low: timeouts, pulse period, saturation.
    step(1'b0, 1'b1);
    r1 = -1; r2 = -1; wrapped = 1'b0; prev_pr = 1'b1;
    for (int i = 1; i <= 256 * 36 + 40; i++) begin
      step(1'b0, 1'b0);
      if (i == 35) chk("tmo_err_before", 32'(timeout_err), 32'd0);
      if (i == 36) chk("tmo_err_at", 32'(timeout_err), 32'd1);
      if (prev_pr === 1'b0 && pll_reset === 1'b1) begin
        if (r1 < 0) r1 = i; else if (r2 < 0) r2 = i;
      end
      if (i > 36 && relock_cnt === 8'd0) wrapped = 1'b1;
      prev_pr = pll_reset;
    end
    chk("pulse_first", r1, 32'd36);
    chk("pulse_period", r2 - r1, 32'd36);
    chk("relock_sat", 32'(relock_cnt), 32'd255);
    chk("relock_wrap", 32'(wrapped), 32'd0);

    // Reach RUN with sticky flags set, then a one-cycle reset pulse.
    seq_times(f_pr, f_st, f_rd);
    chk("sticky_tmo_in_run", 32'(timeout_err), 32'd1);
    step(1'b1, 1'b1);
    chk("rst_pulse_state", 32'(state), 32'd0);
    chk("rst_pulse_relock", 32'(relock_cnt), 32'd0);
    chk("rst_pulse_tmo", 32'(timeout_err), 32'd0);
    seq_times(f_pr, f_st, f_rd);
    chk("rerun_pll_reset_fall", f_pr, 32'd4);
    chk("rerun_settle", f_st, 32'd12);
    chk("rerun_ready", f_rd, 32'd28);

    // Randomized lock behaviour with occasional resets.
    lk = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 39) == 0) lk = ~lk;
      if (!lk && $urandom_range(0, 3) == 0) lk = 1'b1;
      step(lk, ($urandom_range(0, 499) == 0));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
